// File: rtl/core_seq_pkg.sv
// Purpose: shared types and constants for the core instruction sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, 34-bit inst field positions, idle instruction word, address width.
package core_seq_pkg;

  localparam int AW     = 11;  // every SRAM address field is 11 bits
  localparam int INST_W = 34;

  // inst = {acc,CEN_p,WEN_p,A_p[10:0],CEN_x,WEN_x,A_x[10:0],ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_LSB   = 20;
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_LSB   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  // Both SRAMs deselected and in read mode, every strobe low.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    IDLE, WL0, WLOAD, WPAD, XL0, EXEC, DRAIN, ACC
  } state_t;

endpackage

// File: rtl/core_seq_ctrl_conv_addr_gen.sv
// Purpose: walks (output pixel o, kernel position k) pairs for the accumulate phase, producing the input pixel index nij.
// Latency: outputs are a pure function of the registered counters; step takes effect on the next clock.
// Backpressure: none; the owner only pulses step when it has consumed the current pair.
// Ports: clk, clear (sync, wins over step), step (advance k; on k wrap advance o),
//        nij/k/o (11-bit current indices), k_last (k is the final kernel position), last (final k of final o).
module conv_addr_gen
  import core_seq_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int K_W      = 3,
  parameter int O_W      = 4,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_ONIJ = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] nij,
  output logic [AW-1:0] k,
  output logic [AW-1:0] o,
  output logic          k_last,
  output logic          last
);

  localparam logic [AW-1:0] C_INW    = AW'(IN_W);
  localparam logic [AW-1:0] C_KW_M1  = AW'(K_W - 1);
  localparam logic [AW-1:0] C_OW_M1  = AW'(O_W - 1);
  localparam logic [AW-1:0] C_KIJ_M1 = AW'(LEN_KIJ - 1);
  localparam logic [AW-1:0] C_ONJ_M1 = AW'(LEN_ONIJ - 1);

  logic [AW-1:0] kx_q, ky_q, ox_q, oy_q, k_q, o_q;
  logic          o_last;

  assign k_last = (k_q == C_KIJ_M1);
  assign o_last = (o_q == C_ONJ_M1);
  assign last   = k_last && o_last;
  assign k      = k_q;
  assign o      = o_q;
  // Row stride is the input width, so the kernel window slides over the input plane.
  assign nij    = (oy_q + ky_q) * C_INW + ox_q + kx_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0; k_q <= '0; o_q <= '0;
    end else if (step) begin
      if (!k_last) begin
        k_q <= k_q + 1'b1;
        if (kx_q == C_KW_M1) begin
          kx_q <= '0;
          ky_q <= ky_q + 1'b1;
        end else begin
          kx_q <= kx_q + 1'b1;
        end
      end else begin
        k_q <= '0; kx_q <= '0; ky_q <= '0;
        if (o_last) begin
          o_q <= '0; ox_q <= '0; oy_q <= '0;
        end else begin
          o_q <= o_q + 1'b1;
          if (ox_q == C_OW_M1) begin
            ox_q <= '0;
            oy_q <= oy_q + 1'b1;
          end else begin
            ox_q <= ox_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Purpose: drives the 34-bit core instruction word through weight load, activation load, execute, drain and accumulate.
// Latency: registered outputs; first non-idle inst appears in the cycle after start is sampled.
// Backpressure: DRAIN pops only after sampling ofifo_valid=1 and waits indefinitely otherwise.
// Ports: clk, reset (sync, active-high), start (pulse, IDLE only), ofifo_valid,
//        inst[33:0], busy, done (one-cycle pulse at the end of accumulation).
// Option: CORE_SEQ_PERF_EN adds perf_cycles/perf_stall saturating counters.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16,
  parameter int IN_W     = 6,
  parameter int K_W      = 3,
  parameter int O_W      = 4,
  parameter int W_BASE   = 64,
  parameter int OUT_BASE = 1024,
  parameter int LOAD_PAD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  if (ROW < 1 || COL < 1 || LOAD_PAD < 1 || LEN_KIJ != K_W * K_W ||
      O_W != IN_W - K_W + 1 || LEN_ONIJ != O_W * O_W || LEN_NIJ != IN_W * IN_W ||
      W_BASE + LEN_KIJ * COL > 2048 || LEN_KIJ * LEN_NIJ > 2048 ||
      OUT_BASE + LEN_ONIJ > 2048) begin : g_param_err
    $error("core_seq_ctrl: illegal parameter combination");
  end

  localparam logic [AW-1:0] C_COL    = AW'(COL);
  localparam logic [AW-1:0] C_COL_M1 = AW'(COL - 1);
  localparam logic [AW-1:0] C_NIJ    = AW'(LEN_NIJ);
  localparam logic [AW-1:0] C_NIJ_M1 = AW'(LEN_NIJ - 1);
  localparam logic [AW-1:0] C_KIJ_M1 = AW'(LEN_KIJ - 1);
  localparam logic [AW-1:0] C_PAD_M1 = AW'(LOAD_PAD - 1);
  localparam logic [AW-1:0] C_WB     = AW'(W_BASE);
  localparam logic [AW-1:0] C_OB     = AW'(OUT_BASE);

  // state_q and the counters describe the instruction to be issued at the next edge.
  state_t          state_q, state_d, cur;
  logic [AW-1:0]   i_q, i_d, k_q, k_d, j_q, j_d, p_addr_q, p_addr_d;
  logic            wr_pend_q, wr_pend_d, acc_wr_q, acc_wr_d, fin_q, fin_d;
  logic [INST_W-1:0] inst_q, nx;
  logic            busy_q, busy_d, done_q, done_d;
  logic            ag_step, ag_clear, ag_k_last, ag_last;
  logic [AW-1:0]   ag_nij, ag_k, ag_o;

  conv_addr_gen #(
    .IN_W(IN_W), .K_W(K_W), .O_W(O_W), .LEN_KIJ(LEN_KIJ), .LEN_ONIJ(LEN_ONIJ)
  ) u_addr (
    .clk(clk), .clear(reset | ag_clear), .step(ag_step),
    .nij(ag_nij), .k(ag_k), .o(ag_o), .k_last(ag_k_last), .last(ag_last)
  );

  always_comb begin
    // An accepted start issues WL0 step 0 directly; all counters are zero in IDLE.
    cur = state_q;
    if (state_q == IDLE && start) cur = WL0;
    state_d   = cur;
    i_d       = i_q;
    k_d       = k_q;
    j_d       = j_q;
    p_addr_d  = p_addr_q;
    wr_pend_d = 1'b0;
    acc_wr_d  = acc_wr_q;
    fin_d     = 1'b0;
    ag_step   = 1'b0;
    ag_clear  = 1'b0;
    busy_d    = (cur != IDLE);
    done_d    = 1'b0;
    nx        = INST_IDLE;
    nx[INST_IFIFO_WR] = 1'b0;  // the input FIFO is not used by this flow
    nx[INST_IFIFO_RD] = 1'b0;
    case (cur)
      WL0, XL0: begin
        // L0 write lags the xmem read by one cycle for SRAM read latency.
        if (i_q < ((cur == WL0) ? C_COL : C_NIJ)) begin
          nx[INST_CEN_X] = 1'b0;
          nx[INST_AX_LSB +: AW] = (cur == WL0) ? (C_WB + k_q * C_COL + i_q) : i_q;
        end
        if (i_q != '0) nx[INST_L0_WR] = 1'b1;
        if (i_q == ((cur == WL0) ? C_COL : C_NIJ)) begin
          state_d = (cur == WL0) ? WLOAD : EXEC;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      WLOAD: begin
        nx[INST_L0_RD] = 1'b1;
        nx[INST_LOAD]  = 1'b1;
        if (i_q == C_COL_M1) begin state_d = WPAD; i_d = '0; end
        else i_d = i_q + 1'b1;
      end
      WPAD: begin
        if (i_q == C_PAD_M1) begin state_d = XL0; i_d = '0; end
        else i_d = i_q + 1'b1;
      end
      EXEC: begin
        nx[INST_L0_RD]   = 1'b1;
        nx[INST_EXECUTE] = 1'b1;
        if (i_q == C_NIJ_M1) begin state_d = DRAIN; i_d = '0; j_d = '0; end
        else i_d = i_q + 1'b1;
      end
      DRAIN: begin
        // The write for the previous pop may share a cycle with the next pop.
        if (wr_pend_q) begin
          nx[INST_CEN_P] = 1'b0;
          nx[INST_WEN_P] = 1'b0;
          nx[INST_AP_LSB +: AW] = p_addr_q;
        end
        if (ofifo_valid && j_q != C_NIJ) begin
          nx[INST_OFIFO_RD] = 1'b1;
          wr_pend_d = 1'b1;
          p_addr_d  = k_q * C_NIJ + j_q;
          j_d       = j_q + 1'b1;
        end else if (wr_pend_q && j_q == C_NIJ) begin
          j_d = '0;
          i_d = '0;
          if (k_q == C_KIJ_M1) begin
            state_d  = ACC;
            k_d      = '0;
            ag_clear = 1'b1;
            acc_wr_d = 1'b0;
          end else begin
            state_d = WL0;
            k_d     = k_q + 1'b1;
          end
        end
      end
      ACC: begin
        if (fin_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!acc_wr_q) begin
          nx[INST_ACC]   = 1'b1;
          nx[INST_CEN_P] = 1'b0;
          nx[INST_AP_LSB +: AW] = ag_k * C_NIJ + ag_nij;
          if (ag_k_last) acc_wr_d = 1'b1;
          else ag_step = 1'b1;
        end else begin
          nx[INST_CEN_P] = 1'b0;
          nx[INST_WEN_P] = 1'b0;
          nx[INST_AP_LSB +: AW] = C_OB + ag_o;
          acc_wr_d = 1'b0;
          ag_step  = 1'b1;
          if (ag_last) fin_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      k_q       <= '0;
      j_q       <= '0;
      p_addr_q  <= '0;
      wr_pend_q <= 1'b0;
      acc_wr_q  <= 1'b0;
      fin_q     <= 1'b0;
      inst_q    <= INST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      k_q       <= k_d;
      j_q       <= j_d;
      p_addr_q  <= p_addr_d;
      wr_pend_q <= wr_pend_d;
      acc_wr_q  <= acc_wr_d;
      fin_q     <= fin_d;
      inst_q    <= nx;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cyc_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE && start)) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy_q && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (state_q == DRAIN && !ofifo_valid && j_q != C_NIJ && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy, done;

  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;

  int total = 0;
  int bad   = 0;

  // scoreboard state
  int          kcnt, pop_j, pops, dwr, ak, ao, accw;
  logic        prev_rd, pv;
  logic [10:0] exp_pa;

  typedef struct {
    logic        st;
    logic [33:0] inst;
    logic        busy;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic cenx, input logic [10:0] ax, input logic [6:0] ctl);
    logic [33:0] v;
    v = IDLE_I;
    v[19] = cenx;
    v[17:7] = ax;
    v[6:0] = ctl;
    return v;
  endfunction

  function automatic logic [10:0] exp_acc(input int o, input int k);
    int oy, ox, ky, kx;
    oy = o / 4; ox = o % 4; ky = k / 3; kx = k % 3;
    return 11'(k * 36 + (oy + ky) * 6 + ox + kx);
  endfunction

  task automatic mon_reset();
    kcnt = 0; pop_j = 0; pops = 0; dwr = 0; ak = 0; ao = 0; accw = 0;
    prev_rd = 1'b0; exp_pa = '0;
  endtask

  // One clock: sample after the edge and check pmem traffic against the scoreboard.
  task automatic tick();
    logic [33:0] c;
    logic        was_wr;
    pv = ofifo_valid;
    @(posedge clk);
    #1;
    c = inst;
    was_wr = 1'b0;
    if (prev_rd) begin
      chk("drain_wr", {51'd0, c[32:31], c[30:20]}, {51'd0, 2'b00, exp_pa});
      dwr++;
      was_wr = 1'b1;
      if (pop_j == 36) begin kcnt++; pop_j = 0; end
    end
    if (c[6]) begin
      chk("rd_only_when_valid", 64'(pv), 64'd1);
      exp_pa = 11'(kcnt * 36 + pop_j);
      pop_j++;
      pops++;
    end
    prev_rd = c[6];
    if (c[33]) begin
      chk("acc_rd", 64'(c[33:20]), {50'd0, 3'b101, exp_acc(ao, ak)});
      if (ao == 5 && ak == 4) chk("acc_rd_o5_k4", 64'(c[30:20]), 64'd158);
      ak++;
    end else if (kcnt == 9 && !was_wr && c[32:31] == 2'b00) begin
      chk("acc_kcount", 64'(ak), 64'd9);
      chk("acc_wr", 64'(c[30:20]), 64'(1024 + ao));
      if (ao == 5) chk("acc_wr_o5", 64'(c[30:20]), 64'd1029);
      ao++;
      ak = 0;
      accw++;
    end
  endtask

  initial begin
    logic hit, vt, k0_done;
    mon_reset();

    // reset held
    reset = 1'b1;
    repeat (10) tick();
    chk("rst_inst", 64'(inst), 64'(IDLE_I));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    ofifo_valid = 1'b1;

    // start, WL0, WLOAD, first WPAD cycle; row 3 pulses start while busy
    tbl[0] = '{1'b0, IDLE_I, 1'b0};
    tbl[1] = '{1'b1, mk(1'b0, 11'd64, 7'b0000000), 1'b1};
    for (int r = 2; r <= 8; r++)
      tbl[r] = '{(r == 3), mk(1'b0, 11'(64 + r - 1), 7'b0000100), 1'b1};
    tbl[9] = '{1'b0, mk(1'b1, 11'd0, 7'b0000100), 1'b1};
    for (int r = 10; r <= 17; r++)
      tbl[r] = '{1'b0, mk(1'b1, 11'd0, 7'b0001001), 1'b1};
    tbl[18] = '{1'b0, IDLE_I, 1'b1};

    for (int r = 0; r < 19; r++) begin
      start = tbl[r].st;
      tick();
      chk($sformatf("vec%0d_inst", r), 64'(inst), 64'(tbl[r].inst));
      chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
      chk($sformatf("vec%0d_done", r), 64'(done), 64'd0);
    end
    start = 1'b0;

    // run into EXEC of k=3, then abort with reset
    hit = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      tick();
      if (kcnt == 3 && inst[1]) begin hit = 1'b1; break; end
    end
    chk("reach_exec_k3", 64'(hit), 64'd1);
    reset = 1'b1;
    tick();
    chk("abort_inst", 64'(inst), 64'(IDLE_I));
    chk("abort_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    mon_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ax", 64'(inst[19:7]), 64'({2'b01, 11'd64}));
    chk("restart_busy", 64'(busy), 64'd1);

    // full run with ofifo_valid toggling
    vt = 1'b1;
    hit = 1'b0;
    k0_done = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      ofifo_valid = vt;
      vt = ~vt;
      tick();
      if (kcnt == 1 && !k0_done) begin
        chk("k0_pops", 64'(pops), 64'd36);
        k0_done = 1'b1;
      end
      if (done) begin hit = 1'b1; break; end
    end
    chk("done_seen", 64'(hit), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("total_pops", 64'(pops), 64'd324);
    chk("drain_writes", 64'(dwr), 64'd324);
    chk("acc_writes", 64'(accw), 64'd16);
    ofifo_valid = 1'b0;
    tick();
    chk("done_width", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_inst", 64'(inst), 64'(IDLE_I));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
